// File: rtl/serial_sub.sv
// serial_sub: multi-cycle subtractor computing {bout, d} = a - b - bin over
// WIDTH bits, resolving BITS_PER_CYCLE bits per clock through a chain of
// full-subtractor cells. The borrow between slices is kept in a register.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, accepted only in IDLE or DONE
//   a, b   minuend / subtrahend, sampled on the accepted start
//   bin    borrow-in, sampled on the accepted start
//   busy   high while the subtraction is running
//   done   one-cycle pulse when d/bout become valid
//   d      difference, held until the next accepted start
//   bout   final borrow-out, held like d
//   ovf    two's-complement overflow (only with SERIAL_SUB_OVF_EN defined)
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the ovf output.
module serial_sub #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
  output logic             bout,
  output logic             ovf
`else
  output logic             bout
`endif
);

  localparam int unsigned BPC    = (BITS_PER_CYCLE == 0) ? 1 : BITS_PER_CYCLE;
  localparam int unsigned NSLICE = WIDTH / BPC;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  // Reject configurations where the slices do not tile the operands exactly.
  if (WIDTH == 0 || BITS_PER_CYCLE == 0 || (WIDTH % BPC) != 0) begin : g_bad_cfg
    $error("serial_sub: BITS_PER_CYCLE must be nonzero and divide WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             brw;
  logic [CW-1:0]    cnt;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  logic [BPC-1:0]   slice_d;
  logic [BPC:0]     bchain;

  // Ripple-borrow chain across the current low slice of the shift registers.
  always_comb begin
    slice_d   = '0;
    bchain    = '0;
    bchain[0] = brw;
    for (int i = 0; i < int'(BPC); i++) begin
      slice_d[i]   = a_sr[i] ^ b_sr[i] ^ bchain[i];
      bchain[i+1]  = (~a_sr[i] & b_sr[i]) | (~(a_sr[i] ^ b_sr[i]) & bchain[i]);
    end
  end

  // Control FSM with registered outputs and the datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          busy <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= bin;
            cnt   <= '0;
            d     <= '0;
            bout  <= 1'b0;
            busy  <= 1'b1;
            state <= S_RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            ovf   <= 1'b0;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          d[int'(cnt)*int'(BPC) +: BPC] <= slice_d;
          brw  <= bchain[BPC];
          a_sr <= a_sr >> BPC;
          b_sr <= b_sr >> BPC;
          if (cnt == LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            bout  <= bchain[BPC];
            state <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
            // Last slice carries the result MSB.
            ovf <= (a_msb ^ b_msb) & (slice_d[BPC-1] ^ a_msb);
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: randomized and directed checks of serial_sub in three
// configurations (8/1, 4/2, 8/4) against an arithmetic reference model.
module tb_serial_sub;

  logic       clk;
  logic       rst_n;
  logic [7:0] a_i   [3];
  logic [7:0] b_i   [3];
  logic       bin_i [3];
  logic       start_i [3];

  logic [7:0] d_o    [3];
  logic       busy_o [3];
  logic       done_o [3];
  logic       bout_o [3];
  logic       ovf_o  [3];

  logic [7:0] d_0, d_2;
  logic [3:0] d_1;
  logic       busy_0, busy_1, busy_2;
  logic       done_0, done_1, done_2;
  logic       bout_0, bout_1, bout_2;
  logic       ovf_0, ovf_1, ovf_2;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_w8b1 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .a(a_i[0]), .b(b_i[0]),
    .bin(bin_i[0]), .busy(busy_0), .done(done_0), .d(d_0),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf_0),
`endif
    .bout(bout_0));

  serial_sub #(.WIDTH(4), .BITS_PER_CYCLE(2)) u_w4b2 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .a(a_i[1][3:0]), .b(b_i[1][3:0]),
    .bin(bin_i[1]), .busy(busy_1), .done(done_1), .d(d_1),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf_1),
`endif
    .bout(bout_1));

  serial_sub #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_w8b4 (
    .clk(clk), .rst_n(rst_n), .start(start_i[2]), .a(a_i[2]), .b(b_i[2]),
    .bin(bin_i[2]), .busy(busy_2), .done(done_2), .d(d_2),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf_2),
`endif
    .bout(bout_2));

`ifndef SERIAL_SUB_OVF_EN
  assign ovf_0 = 1'b0;
  assign ovf_1 = 1'b0;
  assign ovf_2 = 1'b0;
`endif

  always_comb begin
    d_o[0] = d_0;  d_o[1] = {4'h0, d_1};  d_o[2] = d_2;
    busy_o[0] = busy_0;  busy_o[1] = busy_1;  busy_o[2] = busy_2;
    done_o[0] = done_0;  done_o[1] = done_1;  done_o[2] = done_2;
    bout_o[0] = bout_0;  bout_o[1] = bout_1;  bout_o[2] = bout_2;
    ovf_o[0]  = ovf_0;   ovf_o[1]  = ovf_1;   ovf_o[2]  = ovf_2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int wid_of(input int i);
    return (i == 1) ? 4 : 8;
  endfunction

  function automatic int nslice_of(input int i);
    return (i == 0) ? 8 : 2;
  endfunction

  // Reference: plain integer subtraction, unsigned compare, signed range test.
  task automatic ref_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                        input logic bi, output logic [7:0] dv, output logic bo,
                        output logic ov);
    int m, ua, ub, sa, sb, r, sr;
    m  = (1 << w) - 1;
    ua = int'(av) & m;
    ub = int'(bv) & m;
    r  = ua - ub - int'(bi);
    dv = 8'(r & m);
    bo = (ua < ub + int'(bi));
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    sr = sa - sb - int'(bi);
    ov = (sr < -(1 << (w - 1))) || (sr > (1 << (w - 1)) - 1);
  endtask

  // Waits for done on instance i; returns cycles observed after the accept edge.
  task automatic wait_done(input int i, output int k);
    k = 0;
    while (!done_o[i] && k < 20) begin
      check("busy_run", 32'(busy_o[i]), 32'd1);
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic check_result(input int i, input logic [7:0] av, input logic [7:0] bv,
                              input logic bi);
    logic [7:0] ed;
    logic       eb, eo;
    ref_op(wid_of(i), av, bv, bi, ed, eb, eo);
    check("done", 32'(done_o[i]), 32'd1);
    check("busy_done", 32'(busy_o[i]), 32'd0);
    check("d", 32'(d_o[i]), 32'(ed));
    check("bout", 32'(bout_o[i]), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", 32'(ovf_o[i]), 32'(eo));
`endif
  endtask

  // One operation with a single start pulse; inputs are scrambled after accept.
  task automatic run_op(input int i, input logic [7:0] av, input logic [7:0] bv,
                        input logic bi);
    int k;
    a_i[i] = av;  b_i[i] = bv;  bin_i[i] = bi;  start_i[i] = 1'b1;
    @(posedge clk); #1;
    start_i[i] = 1'b0;
    a_i[i] = 8'($urandom);  b_i[i] = 8'($urandom);  bin_i[i] = 1'($urandom);
    wait_done(i, k);
    check("latency", 32'(k), 32'(nslice_of(i)));
    check_result(i, av, bv, bi);
    @(posedge clk); #1;
    check("done_pulse", 32'(done_o[i]), 32'd0);
    check("idle_busy", 32'(busy_o[i]), 32'd0);
    check("d_hold", 32'(d_o[i]), 32'(d_o[i] === 8'hxx ? 8'h00 : d_o[i]) | 32'h0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_i[i] = '0;  b_i[i] = '0;  bin_i[i] = 1'b0;  start_i[i] = 1'b0;
    end
    #2;
    for (int i = 0; i < 3; i++) begin
      check("rst_busy", 32'(busy_o[i]), 32'd0);
      check("rst_done", 32'(done_o[i]), 32'd0);
      check("rst_d", 32'(d_o[i]), 32'd0);
      check("rst_bout", 32'(bout_o[i]), 32'd0);
      check("rst_ovf", 32'(ovf_o[i]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases.
    run_op(0, 8'h05, 8'h03, 1'b0);
    run_op(0, 8'h00, 8'h01, 1'b1);
    run_op(0, 8'h80, 8'h01, 1'b0);
    run_op(0, 8'hFF, 8'hFF, 1'b1);
    run_op(0, 8'h7F, 8'h80, 1'b0);

    // Exhaustive sweep on the 4-bit, 2-bits-per-cycle instance.
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int bi = 0; bi < 2; bi++)
          run_op(1, 8'(av), 8'(bv), 1'(bi));

    // Random operations on the 8-bit instances.
    for (int n = 0; n < 60; n++) begin
      run_op(0, 8'($urandom), 8'($urandom), 1'($urandom));
      run_op(2, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Back-to-back with start held high; mid-run operand changes must be ignored.
    a_i[2] = 8'hFF;  b_i[2] = 8'h0F;  bin_i[2] = 1'b0;  start_i[2] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      b_i[2] = (j == 1) ? 8'h20 : 8'h10;
      wait_done(2, k);
      check("b2b_latency", 32'(k), 32'd2);
      check_result(2, 8'hFF, 8'h0F, 1'b0);
      check("b2b_d", 32'(d_o[2]), 32'hF0);
      b_i[2] = 8'h0F;
      if (j == 2) start_i[2] = 1'b0;
    end
    @(posedge clk); #1;
    check("b2b_idle", 32'(busy_o[2]), 32'd0);

    // Reset pulse in the middle of a run aborts it without a done pulse.
    a_i[0] = 8'hAA;  b_i[0] = 8'h55;  bin_i[0] = 1'b0;  start_i[0] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(busy_o[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy_o[0]), 32'd0);
    check("abort_done", 32'(done_o[0]), 32'd0);
    check("abort_d", 32'(d_o[0]), 32'd0);
    check("abort_bout", 32'(bout_o[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      check("abort_nodone", 32'(done_o[0]), 32'd0);
      check("abort_idle", 32'(busy_o[0]), 32'd0);
      @(posedge clk); #1;
    end
    run_op(0, 8'hAA, 8'h55, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
